mac3_sched: RTL and testbench
=============================

Name: mac3_sched

Overview:
- Sequencer for the 3-tap pipelined MAC datapath (4 register stages, every stage enabled only by its input_valid).
- Accepts a job configuration: G three-tap groups per output, N outputs.
- Pulls operand triplets from the operand-fetch unit and drives the MAC's input_valid, accumulate_internal and ch_out.
- Tracks which pipeline slot holds a finished result, inserts zero-operand bubbles to drain the pipe, and presents results to the writeback side with valid/ready backpressure.

Parameters:
- CNT_WIDTH, 8, width of the group and output counters and their config fields.
- CH_WIDTH, 32, width of the channel index driven to the MAC ch_out input.
- PIPE_DEPTH, 4, MAC issue-to-result depth in input_valid pulses; only 4 is supported.

Ports:
- clk  in  1  clock
- arst_n_in  in  1  asynchronous reset, active low
- cfg_valid  in  1  job config offered
- cfg_ready  out  1  controller accepts config (IDLE only)
- cfg_groups  in  CNT_WIDTH  G, groups per output
- cfg_outputs  in  CNT_WIDTH  N, outputs per job
- op_valid  in  1  operand triplet available at MAC a/b inputs
- op_ready  out  1  triplet consumed this cycle
- mac_input_valid  out  1  advance MAC pipeline
- mac_accumulate_internal  out  1  0 = restart from partial_sum_in, 1 = accumulate
- mac_operand_zero  out  1  operand mux forces a0..b2 to 0 (bubble)
- mac_ch_out  out  CH_WIDTH  output index tagged into MAC
- res_valid  out  1  MAC out holds a finished result
- res_ready  in  1  writeback takes result
- res_last  out  1  result is output N-1 of the job
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when job fully drained

Behaviour:
- Reset (async, arst_n_in=0): state IDLE, all counters and tags 0. All outputs 0 except cfg_ready=1. Reset mid-job abandons the job and emits no done.
- States: IDLE, RUN, DRAIN.
- IDLE -> RUN on cfg_valid & cfg_ready; latch G and N, clear g_cnt and o_cnt.
- If G==0 or N==0, go to DRAIN directly. DRAIN with empty tags gives done the next cycle with zero issues.
- Stall: stall = res_valid & ~res_ready.
- RUN:
  - op_ready = ~stall.
  - Issue = op_valid & op_ready; mac_input_valid = issue, mac_operand_zero = 0.
  - mac_accumulate_internal = (g_cnt != 0); mac_ch_out = o_cnt zero-extended.
  - On issue, g_cnt increments. At g_cnt==G-1 it wraps to 0 and o_cnt increments.
  - The issue with g_cnt==G-1 and o_cnt==N-1 moves to DRAIN.
- DRAIN:
  - If any of tag[0..2] is set and ~stall: mac_input_valid=1, mac_operand_zero=1, mac_accumulate_internal=1. A bubble adds 0 and preserves the accumulator value.
  - When tag[0..3] are all 0: done=1 for one cycle, go to IDLE.
- Tag pipe: PIPE_DEPTH entries of {final, last}.
  - On every mac_input_valid, shift: tag[0] gets the issue's flags, where final = (g_cnt==G-1) and last = final & (o_cnt==N-1); bubbles enter {0,0}.
  - Result appears 3 pulses after its final issue: res_valid = tag[3].final, res_last = tag[3].last.
  - On res_valid & res_ready with no shift, clear tag[3]. Accept and shift in the same cycle is legal; the shift value wins.
- No issue or bubble is ever generated while stall=1, so the MAC's stage-4 register is never overwritten before the result is accepted.
- cfg_valid outside IDLE is ignored (cfg_ready=0).
- op_valid outside RUN is ignored (op_ready=0).

Test Plan:
- G=2, N=3, op_valid=1, res_ready=1 -> 6 operand issues then 3 bubbles (9 mac_input_valid pulses). res_valid after pulses 5, 7, 9; res_last only on the third. mac_accumulate_internal pattern 0,1,0,1,0,1,1,1,1. done one cycle after the final tag clears.
- G=1, N=4 with drive a*b=1 each -> mac_accumulate_internal always 0 for operand issues. Four results, each equal to partial_sum_in+3; mac_ch_out values 0,1,2,3.
- G=3, N=2, res_ready held 0 for 5 cycles at the first res_valid -> op_ready=0 and mac_input_valid=0 throughout. Result value is unchanged across the stall; the flow resumes the cycle after res_ready=1.
- op_valid toggling 1,0,1,0 with G=4, N=1 -> g_cnt advances only on handshakes. Exactly 4 issues and 3 bubbles; one result equal to the sum of 12 products.
- cfg_groups=0 -> no mac_input_valid, done pulse within 2 cycles, busy drops.
- arst_n_in pulsed low during DRAIN with tags set -> all outputs 0 except cfg_ready=1, no done pulse; a new config is accepted immediately after release.

Source files
------------

// File: rtl/mac3_sched.sv
// mac3_sched: issue sequencer for the 3-tap pipelined MAC. It walks G groups x N outputs,
// tracks finished results through the pipe with a tag shift register, drains the pipe
// with zero-operand bubbles and hands results to writeback under valid/ready.
module mac3_sched #(
   parameter int unsigned CNT_WIDTH  = 8,
   parameter int unsigned CH_WIDTH   = 32,
   parameter int unsigned PIPE_DEPTH = 4   // MAC issue-to-result depth; the datapath is built for 4
) (
   input  logic                 clk,
   input  logic                 arst_n_in,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [CNT_WIDTH-1:0] cfg_groups,
   input  logic [CNT_WIDTH-1:0] cfg_outputs,
   input  logic                 op_valid,
   output logic                 op_ready,
   output logic                 mac_input_valid,
   output logic                 mac_accumulate_internal,
   output logic                 mac_operand_zero,
   output logic [CH_WIDTH-1:0]  mac_ch_out,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic                 res_last,
   output logic                 busy,
   output logic                 done
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   // fin: this pulse completes an output; lst: that output is the last of the job
   typedef struct packed {
      logic fin;
      logic lst;
   } tag_t;

   state_e                  state_q, state_d;
   logic [CNT_WIDTH-1:0]    grp_max_q, grp_max_d;
   logic [CNT_WIDTH-1:0]    out_max_q, out_max_d;
   logic [CNT_WIDTH-1:0]    g_cnt_q, g_cnt_d;
   logic [CNT_WIDTH-1:0]    o_cnt_q, o_cnt_d;
   tag_t [PIPE_DEPTH-1:0]   tag_q, tag_d;
   tag_t                    issue_tag;
   logic                    stall;
   logic                    pending;
   logic                    tags_empty;
   logic                    last_grp;
   logic                    last_out;

   // The oldest tag slot lines up with the MAC output register
   assign res_valid  = tag_q[PIPE_DEPTH-1].fin;
   assign res_last   = tag_q[PIPE_DEPTH-1].lst;
   assign busy       = (state_q != ST_IDLE);
   assign stall      = res_valid & ~res_ready;
   assign last_grp   = (g_cnt_q == grp_max_q - CNT_ONE);
   assign last_out   = (o_cnt_q == out_max_q - CNT_ONE);
   assign tags_empty = (tag_q == '0);

   // A finished result still travelling through the front slots needs bubbles to reach the output
   always_comb begin
      pending = 1'b0;
      for (int unsigned i = 0; i < PIPE_DEPTH - 1; i++) begin
         pending = pending | tag_q[i].fin;
      end
   end

   // Next-state, counters, tag pipe and MAC/handshake controls
   always_comb begin
      state_d                 = state_q;
      grp_max_d               = grp_max_q;
      out_max_d               = out_max_q;
      g_cnt_d                 = g_cnt_q;
      o_cnt_d                 = o_cnt_q;
      tag_d                   = tag_q;
      issue_tag               = '0;
      cfg_ready               = 1'b0;
      op_ready                = 1'b0;
      mac_input_valid         = 1'b0;
      mac_accumulate_internal = 1'b0;
      mac_operand_zero        = 1'b0;
      mac_ch_out              = '0;
      done                    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cfg_ready = 1'b1;
            if (cfg_valid) begin
               grp_max_d = cfg_groups;
               out_max_d = cfg_outputs;
               g_cnt_d   = '0;
               o_cnt_d   = '0;
               state_d   = ((cfg_groups == '0) || (cfg_outputs == '0)) ? ST_DRAIN : ST_RUN;
            end
         end

         ST_RUN: begin
            op_ready                = ~stall;
            mac_input_valid         = op_valid & ~stall;
            mac_accumulate_internal = (g_cnt_q != '0);
            mac_ch_out              = CH_WIDTH'(o_cnt_q);
            if (mac_input_valid) begin
               issue_tag.fin = last_grp;
               issue_tag.lst = last_grp & last_out;
               if (last_grp) begin
                  g_cnt_d = '0;
                  o_cnt_d = o_cnt_q + CNT_ONE;
                  if (last_out) begin
                     state_d = ST_DRAIN;
                  end
               end else begin
                  g_cnt_d = g_cnt_q + CNT_ONE;
               end
            end
         end

         ST_DRAIN: begin
            if (pending) begin
               // zero operands with accumulate keep the in-flight sums intact
               if (!stall) begin
                  mac_input_valid         = 1'b1;
                  mac_operand_zero        = 1'b1;
                  mac_accumulate_internal = 1'b1;
               end
            end else if (tags_empty) begin
               done    = 1'b1;
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      // A pipe advance always retires the output slot; it can only happen when that slot is free or taken
      if (mac_input_valid) begin
         tag_d = {tag_q[PIPE_DEPTH-2:0], issue_tag};
      end else if (res_valid && res_ready) begin
         tag_d[PIPE_DEPTH-1] = '0;
      end
   end

   // State and datapath-control registers
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         state_q   <= ST_IDLE;
         grp_max_q <= '0;
         out_max_q <= '0;
         g_cnt_q   <= '0;
         o_cnt_q   <= '0;
         tag_q     <= '0;
      end else begin
         state_q   <= state_d;
         grp_max_q <= grp_max_d;
         out_max_q <= out_max_d;
         g_cnt_q   <= g_cnt_d;
         o_cnt_q   <= o_cnt_d;
         tag_q     <= tag_d;
      end
   end

endmodule

// File: tb/tb_mac3_sched.sv
// tb_mac3_sched: directed and randomized jobs against a job-level reference model that
// predicts every handshake from issue/pulse/result counts.
module tb_mac3_sched;

   localparam int unsigned CW  = 8;
   localparam int unsigned CHW = 32;

   logic           clk = 1'b0;
   logic           arst_n_in;
   logic           cfg_valid;
   logic           cfg_ready;
   logic [CW-1:0]  cfg_groups;
   logic [CW-1:0]  cfg_outputs;
   logic           op_valid;
   logic           op_ready;
   logic           mac_input_valid;
   logic           mac_accumulate_internal;
   logic           mac_operand_zero;
   logic [CHW-1:0] mac_ch_out;
   logic           res_valid;
   logic           res_ready;
   logic           res_last;
   logic           busy;
   logic           done;

   mac3_sched #(.CNT_WIDTH(CW), .CH_WIDTH(CHW), .PIPE_DEPTH(4)) dut (
      .clk                     (clk),
      .arst_n_in               (arst_n_in),
      .cfg_valid               (cfg_valid),
      .cfg_ready               (cfg_ready),
      .cfg_groups              (cfg_groups),
      .cfg_outputs             (cfg_outputs),
      .op_valid                (op_valid),
      .op_ready                (op_ready),
      .mac_input_valid         (mac_input_valid),
      .mac_accumulate_internal (mac_accumulate_internal),
      .mac_operand_zero        (mac_operand_zero),
      .mac_ch_out              (mac_ch_out),
      .res_valid               (res_valid),
      .res_ready               (res_ready),
      .res_last                (res_last),
      .busy                    (busy),
      .done                    (done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // job-level reference state: counts only
   bit m_active = 1'b0;
   int m_g = 0, m_n = 0, m_issued = 0, m_pulses = 0, m_acc = 0;

   // expected outputs for the current cycle
   bit e_cfg_ready, e_busy, e_op_ready, e_miv, e_zero, e_acc, e_res_valid, e_res_last, e_done, e_run;
   int e_ch;

   // observed per-job totals
   int obs_pulses, obs_results, obs_lasts;
   int hold_req, hold_left;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Expected behaviour from the job rules: issue k belongs to output k/G, result j leaves after
   // pulse (j+1)*G+3, three bubbles follow the last issue.
   task automatic compute_exp();
      int total_issues, total_pulses;
      bit drain, stall;
      total_issues = m_g * m_n;
      total_pulses = (total_issues == 0) ? 0 : total_issues + 3;
      e_run        = m_active && (m_issued < total_issues);
      drain        = m_active && !e_run;
      e_res_valid  = m_active && (total_issues != 0) && (m_acc < m_n) &&
                     (m_pulses == (m_acc + 1) * m_g + 3);
      e_res_last   = e_res_valid && (m_acc == m_n - 1);
      stall        = e_res_valid && !res_ready;
      e_op_ready   = e_run && !stall;
      if (e_run) e_miv = op_valid && !stall;
      else       e_miv = drain && !stall && (m_pulses < total_pulses);
      e_zero       = drain && e_miv;
      e_acc        = 1'b1;
      e_ch         = 0;
      if (e_run) begin
         e_acc = (m_issued % m_g) != 0;
         e_ch  = m_issued / m_g;
      end
      e_done       = drain && (m_pulses == total_pulses) &&
                     (m_acc == ((total_issues == 0) ? 0 : m_n));
      e_busy       = m_active;
      e_cfg_ready  = !m_active;
   endtask

   task automatic advance_model();
      if (cfg_valid && e_cfg_ready) begin
         m_active = 1'b1;
         m_g      = int'(cfg_groups);
         m_n      = int'(cfg_outputs);
         m_issued = 0;
         m_pulses = 0;
         m_acc    = 0;
      end else if (m_active) begin
         if (e_miv) begin
            m_pulses++;
            if (m_issued < m_g * m_n) m_issued++;
         end
         if (e_res_valid && res_ready) m_acc++;
         if (e_done) m_active = 1'b0;
      end
   endtask

   // One clock: compare at the falling edge, then step the model across the rising edge.
   task automatic tick();
      @(negedge clk);
      compute_exp();
      check("cfg_ready", 64'(cfg_ready), 64'(e_cfg_ready));
      check("busy", 64'(busy), 64'(e_busy));
      check("op_ready", 64'(op_ready), 64'(e_op_ready));
      check("mac_input_valid", 64'(mac_input_valid), 64'(e_miv));
      check("mac_operand_zero", 64'(mac_operand_zero), 64'(e_zero));
      check("res_valid", 64'(res_valid), 64'(e_res_valid));
      check("res_last", 64'(res_last), 64'(e_res_last));
      check("done", 64'(done), 64'(e_done));
      if (e_miv) check("mac_accumulate_internal", 64'(mac_accumulate_internal), 64'(e_acc));
      if (e_run) check("mac_ch_out", 64'(mac_ch_out), 64'(e_ch));
      if (mac_input_valid === 1'b1) obs_pulses++;
      if (res_valid === 1'b1 && res_ready) begin
         obs_results++;
         if (res_last === 1'b1) obs_lasts++;
      end
      advance_model();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_cfg_ready"}, 64'(cfg_ready), 64'd1);
      check({pfx, "_busy"}, 64'(busy), 64'd0);
      check({pfx, "_op_ready"}, 64'(op_ready), 64'd0);
      check({pfx, "_mac_input_valid"}, 64'(mac_input_valid), 64'd0);
      check({pfx, "_mac_accumulate_internal"}, 64'(mac_accumulate_internal), 64'd0);
      check({pfx, "_mac_operand_zero"}, 64'(mac_operand_zero), 64'd0);
      check({pfx, "_mac_ch_out"}, 64'(mac_ch_out), 64'd0);
      check({pfx, "_res_valid"}, 64'(res_valid), 64'd0);
      check({pfx, "_res_last"}, 64'(res_last), 64'd0);
      check({pfx, "_done"}, 64'(done), 64'd0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         cfg_valid = 1'b0;
         op_valid  = ($urandom_range(1) == 1);
         res_ready = ($urandom_range(1) == 1);
         tick();
      end
   endtask

   // op_mode 0: op_valid with probability op_pct; op_mode 1: op_valid toggles 1,0,1,0 from job start.
   // hold > 0 keeps res_ready low for that many cycles at the first visible result.
   task automatic run_job(input int g, input int n, input int op_mode, input int op_pct,
                          input int rdy_pct, input int hold, input bit abort_in_drain);
      bit started, ended, op_tog;
      int exp_pulses;
      started     = 1'b0;
      ended       = 1'b0;
      op_tog      = 1'b1;
      obs_pulses  = 0;
      obs_results = 0;
      obs_lasts   = 0;
      hold_req    = hold;
      hold_left   = 0;
      exp_pulses  = (g * n == 0) ? 0 : g * n + 3;
      for (int k = 0; k < 4000 && !ended; k++) begin
         compute_exp();
         if (!started) begin
            cfg_valid   = 1'b1;
            cfg_groups  = CW'(g);
            cfg_outputs = CW'(n);
         end else begin
            cfg_valid   = ($urandom_range(3) == 0);
            cfg_groups  = CW'($urandom);
            cfg_outputs = CW'($urandom);
         end
         if (op_mode == 1) begin
            op_valid = started ? op_tog : 1'b0;
            if (started) op_tog = ~op_tog;
         end else begin
            op_valid = ($urandom_range(99) < 32'(op_pct));
         end
         if (hold_left > 0) begin
            res_ready = 1'b0;
            hold_left--;
         end else if (hold_req > 0 && e_res_valid) begin
            res_ready = 1'b0;
            hold_left = hold_req - 1;
            hold_req  = 0;
         end else begin
            res_ready = ($urandom_range(99) < 32'(rdy_pct));
         end
         tick();
         if (m_active) started = 1'b1;
         else if (started) ended = 1'b1;
         if (abort_in_drain && m_active && (m_issued == m_g * m_n) && (m_pulses < exp_pulses)) begin
            // pipe still holds tagged work: pull reset mid-cycle
            cfg_valid = 1'b0;
            #2 arst_n_in = 1'b0;
            #1 check_reset_outputs("rst_drain");
            m_active = 1'b0;
            idle(2);
            arst_n_in = 1'b1;
            return;
         end
      end
      check("job_end", 64'(ended), 64'd1);
      check("job_pulses", 64'(obs_pulses), 64'(exp_pulses));
      check("job_results", 64'((g * n == 0) ? 0 : n), 64'(obs_results));
      check("job_last_count", 64'(obs_lasts), 64'((g * n == 0) ? 0 : 1));
      cfg_valid = 1'b0;
   endtask

   initial begin
      arst_n_in   = 1'b0;
      cfg_valid   = 1'b0;
      cfg_groups  = '0;
      cfg_outputs = '0;
      op_valid    = 1'b0;
      res_ready   = 1'b0;
      #3 check_reset_outputs("reset");
      @(posedge clk);
      #1 arst_n_in = 1'b1;
      idle(2);

      run_job(2, 3, 0, 100, 100, 0, 1'b0);   // 6 issues + 3 bubbles, results at pulses 5,7,9
      idle(1);
      run_job(1, 4, 0, 100, 100, 0, 1'b0);   // no accumulate, ch 0..3
      idle(1);
      run_job(3, 2, 0, 100, 100, 5, 1'b0);   // 5-cycle writeback stall at first result
      idle(1);
      run_job(4, 1, 1, 100, 100, 0, 1'b0);   // operands only every other cycle
      idle(1);
      run_job(0, 5, 0, 100, 100, 0, 1'b0);   // zero groups: straight to done
      run_job(3, 0, 0, 100, 100, 0, 1'b0);   // zero outputs
      idle(1);
      run_job(2, 2, 0, 100, 100, 0, 1'b1);   // reset while draining
      run_job(2, 2, 0, 100, 100, 0, 1'b0);   // accepted right after release
      run_job(1, 20, 0, 70, 60, 0, 1'b0);    // longer channel sweep under backpressure

      for (int j = 0; j < 14; j++) begin
         run_job(int'($urandom_range(4)), int'($urandom_range(5)), int'($urandom_range(1)),
                 int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                 int'($urandom_range(3)), 1'b0);
         idle(int'($urandom_range(2)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
